// File: rtl/input_conditioner_pkg.sv
// input_conditioner_pkg: shared types and widths for the input conditioner.
package input_conditioner_pkg;

  localparam int SYM_W = 2;

  typedef enum logic {
    STABLE = 1'b0,
    COUNT  = 1'b1
  } ic_state_t;

endpackage

// File: rtl/input_conditioner_sync2.sv
// sync2: two-flop synchronizer for the raw SYM_W-bit input levels.
// Asynchronous active-low reset clears both stages.
module sync2
  import input_conditioner_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic [SYM_W-1:0] d,
  output logic [SYM_W-1:0] q
);

  logic [SYM_W-1:0] s1_r;
  logic [SYM_W-1:0] s2_r;

  // Two back-to-back capture stages; only the second stage is used downstream.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_r <= {SYM_W{1'b0}};
      s2_r <= {SYM_W{1'b0}};
    end else begin
      s1_r <= d;
      s2_r <= s1_r;
    end
  end

  assign q = s2_r;

endmodule

// File: rtl/input_conditioner.sv
// input_conditioner: synchronizes and debounces a 2-bit raw input vector and
// presents a clean registered symbol plus a one-cycle change strobe.
// Optional macro INPUT_CONDITIONER_REPEAT_EN adds an auto-repeat strobe while
// a non-zero symbol is held (period REPEAT_CYCLES).
module input_conditioner
  import input_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
`ifdef INPUT_CONDITIONER_REPEAT_EN
  , parameter int REPEAT_CYCLES = 16
`endif
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [SYM_W-1:0] raw_in,
  output logic [SYM_W-1:0] sym,
  output logic             sym_valid,
  output logic             busy
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYM_W-1:0] s2_s;
  ic_state_t        state_r, state_s;
  logic [SYM_W-1:0] cand_r, cand_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic [SYM_W-1:0] sym_r, sym_s;
  logic             commit_s;
  logic             strobe_s;
  logic             sym_valid_r;

  sync2 u_sync2 (
    .clk   (clk),
    .reset (reset),
    .d     (raw_in),
    .q     (s2_s)
  );

  // Debounce next-state: glitch rejection takes priority over bounce restart,
  // which takes priority over commit.
  always_comb begin
    state_s  = state_r;
    cand_s   = cand_r;
    cnt_s    = cnt_r;
    sym_s    = sym_r;
    commit_s = 1'b0;
    case (state_r)
      STABLE: begin
        if (s2_s != sym_r) begin
          cand_s  = s2_s;
          cnt_s   = CNT_ONE;
          state_s = COUNT;
        end else begin
          cnt_s = CNT_ZERO;
        end
      end
      COUNT: begin
        if (s2_s == sym_r) begin
          state_s = STABLE;
          cnt_s   = CNT_ZERO;
        end else if (s2_s != cand_r) begin
          cand_s = s2_s;
          cnt_s  = CNT_ONE;
        end else if (cnt_r == CNT_LAST) begin
          sym_s    = cand_r;
          commit_s = 1'b1;
          cnt_s    = CNT_ZERO;
          state_s  = STABLE;
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      default: begin
        state_s = STABLE;
        cnt_s   = CNT_ZERO;
      end
    endcase
  end

`ifdef INPUT_CONDITIONER_REPEAT_EN
  localparam int RPT_W = $clog2(REPEAT_CYCLES);
  localparam logic [RPT_W-1:0] RPT_ZERO = {RPT_W{1'b0}};
  localparam logic [RPT_W-1:0] RPT_ONE  = RPT_W'(1);
  localparam logic [RPT_W-1:0] RPT_LAST = RPT_W'(REPEAT_CYCLES - 1);

  logic [RPT_W-1:0] rpt_r, rpt_s;
  logic             rpt_fire_s;

  // Auto-repeat: count only while settled on a non-zero symbol; any other
  // condition (leaving STABLE, idle symbol) restarts the period.
  always_comb begin
    rpt_s      = RPT_ZERO;
    rpt_fire_s = 1'b0;
    if ((state_r == STABLE) && (s2_s == sym_r) && (sym_r != {SYM_W{1'b0}})) begin
      if (rpt_r == RPT_LAST) begin
        rpt_fire_s = 1'b1;
        rpt_s      = RPT_ZERO;
      end else begin
        rpt_s = rpt_r + RPT_ONE;
      end
    end else begin
      rpt_s = RPT_ZERO;
    end
  end

  // Repeat period counter register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rpt_r <= RPT_ZERO;
    end else begin
      rpt_r <= rpt_s;
    end
  end

  assign strobe_s = commit_s | rpt_fire_s;
`else
  assign strobe_s = commit_s;
`endif

  // Debounce state, candidate, counter, committed symbol and strobe registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= STABLE;
      cand_r      <= {SYM_W{1'b0}};
      cnt_r       <= CNT_ZERO;
      sym_r       <= {SYM_W{1'b0}};
      sym_valid_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      cand_r      <= cand_s;
      cnt_r       <= cnt_s;
      sym_r       <= sym_s;
      sym_valid_r <= strobe_s;
    end
  end

  assign sym       = sym_r;
  assign sym_valid = sym_valid_r;
  assign busy      = (state_r == COUNT);

endmodule

// File: tb/tb_input_conditioner.sv
// tb_input_conditioner: randomized and directed checks of input_conditioner
// against a run-length reference model of the debounce rules.
module tb_input_conditioner;

  localparam int D = 4;
  localparam int R = 16;

  logic       clk;
  logic       reset;
  logic [1:0] raw_in;
  logic [1:0] sym;
  logic       sym_valid;
  logic       busy;

  int n_assert;
  int n_fail;

  // Reference model: two-stage delay line, then "a new value must be seen
  // D edges in a row" expressed as a run length of identical samples.
  logic [1:0] m_s1, m_s2, m_prev, m_sym;
  int         m_run;
  int         m_rpt;
  logic       m_valid;

  input_conditioner #(
    .DEBOUNCE_CYCLES(D)
`ifdef INPUT_CONDITIONER_REPEAT_EN
    , .REPEAT_CYCLES(R)
`endif
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .raw_in    (raw_in),
    .sym       (sym),
    .sym_valid (sym_valid),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    m_s1 = 2'b00; m_s2 = 2'b00; m_prev = 2'b00; m_sym = 2'b00;
    m_run = 0; m_rpt = 0; m_valid = 1'b0;
  endtask

  task automatic model_edge(input logic [1:0] v);
    logic [1:0] seen;
    logic [1:0] sym_before;
    bit         settled;
    seen       = m_s2;
    sym_before = m_sym;
    settled    = (m_run == 0);
    m_valid    = 1'b0;
    if (seen == m_sym) m_run = 0;
    else if (m_run > 0 && seen == m_prev) m_run = m_run + 1;
    else m_run = 1;
    m_prev = seen;
    if (m_run == D) begin
      m_sym   = seen;
      m_valid = 1'b1;
      m_run   = 0;
    end
`ifdef INPUT_CONDITIONER_REPEAT_EN
    if (settled && seen == sym_before && sym_before != 2'b00) begin
      m_rpt = m_rpt + 1;
      if (m_rpt == R) begin
        m_valid = 1'b1;
        m_rpt   = 0;
      end
    end else begin
      m_rpt = 0;
    end
`endif
    m_s2 = m_s1;
    m_s1 = v;
  endtask

  // Drive one value for one clock, advance the model, settle past the edge.
  task automatic step(input logic [1:0] v);
    raw_in = v;
    @(posedge clk);
    model_edge(v);
    #1;
  endtask

  task automatic test_reset();
    reset  = 1'b0;
    raw_in = 2'b11;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      n_assert++;
      if (sym !== 2'b00 || sym_valid !== 1'b0 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL reset cyc%0d: sym=%b valid=%b busy=%b, want 00 0 0", i, sym, sym_valid, busy);
      end
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_clean();
    int strobes, busy_cycles;
    strobes = 0; busy_cycles = 0;
    for (int i = 0; i < 4; i++) step(2'b00);
    for (int i = 0; i < 10; i++) begin
      step(2'b01);
      if (sym_valid) strobes++;
      if (busy) busy_cycles++;
      n_assert++;
      if (sym !== m_sym || sym_valid !== m_valid || busy !== (m_run > 0)) begin
        n_fail++;
        $display("FAIL clean cyc%0d: sym=%b valid=%b busy=%b, want %b %b %b",
                 i, sym, sym_valid, busy, m_sym, m_valid, (m_run > 0));
      end
    end
    n_assert++;
    if (strobes != 1 || busy_cycles != D - 1 || sym !== 2'b01) begin
      n_fail++;
      $display("FAIL clean summary: strobes=%0d busy=%0d sym=%b, want 1 %0d 01", strobes, busy_cycles, sym, D - 1);
    end
  endtask

  task automatic test_glitch();
    int strobes, busy_cycles;
    strobes = 0; busy_cycles = 0;
    for (int i = 0; i < 6; i++) step(2'b00);
    step(2'b10);
    for (int i = 0; i < 8; i++) begin
      step(2'b00);
      if (sym_valid) strobes++;
      if (busy) busy_cycles++;
      n_assert++;
      if (sym !== m_sym || sym_valid !== m_valid || busy !== (m_run > 0)) begin
        n_fail++;
        $display("FAIL glitch cyc%0d: sym=%b valid=%b busy=%b, want %b %b %b",
                 i, sym, sym_valid, busy, m_sym, m_valid, (m_run > 0));
      end
    end
    n_assert++;
    if (strobes != 0 || busy_cycles != 1 || sym !== 2'b00) begin
      n_fail++;
      $display("FAIL glitch summary: strobes=%0d busy=%0d sym=%b, want 0 1 00", strobes, busy_cycles, sym);
    end
  endtask

  task automatic test_bounce();
    int strobes, busy_cycles;
    strobes = 0; busy_cycles = 0;
    step(2'b11);
    if (busy) busy_cycles++;
    for (int i = 0; i < 10; i++) begin
      step(2'b10);
      if (sym_valid) strobes++;
      if (busy) busy_cycles++;
      n_assert++;
      if (sym !== m_sym || sym_valid !== m_valid || busy !== (m_run > 0)) begin
        n_fail++;
        $display("FAIL bounce cyc%0d: sym=%b valid=%b busy=%b, want %b %b %b",
                 i, sym, sym_valid, busy, m_sym, m_valid, (m_run > 0));
      end
    end
    // One cycle counting 11, then a full restart of D-1 busy cycles for 10.
    n_assert++;
    if (strobes != 1 || busy_cycles != D || sym !== 2'b10) begin
      n_fail++;
      $display("FAIL bounce summary: strobes=%0d busy=%0d sym=%b, want 1 %0d 10", strobes, busy_cycles, sym, D);
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] seq[$];
    logic       prev_v;
    bit         dbl;
    for (int i = 0; i < 10; i++) step(2'b00);
    prev_v = sym_valid;
    dbl    = 1'b0;
    for (int i = 0; i < 14; i++) begin
      step((i < 6) ? 2'b01 : 2'b11);
      if (sym_valid) seq.push_back(sym);
      if (sym_valid && prev_v) dbl = 1'b1;
      prev_v = sym_valid;
      n_assert++;
      if (sym !== m_sym || sym_valid !== m_valid) begin
        n_fail++;
        $display("FAIL b2b cyc%0d: sym=%b valid=%b, want %b %b", i, sym, sym_valid, m_sym, m_valid);
      end
    end
    n_assert++;
    if (seq.size() != 2 || dbl) begin
      n_fail++;
      $display("FAIL b2b strobes: count=%0d double=%0d, want 2 0", seq.size(), dbl);
    end else begin
      n_assert++;
      if (seq[0] !== 2'b01 || seq[1] !== 2'b11) begin
        n_fail++;
        $display("FAIL b2b sequence: %b,%b, want 01,11", seq[0], seq[1]);
      end
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) step(2'b01);
    n_assert++;
    if (busy !== 1'b1 || sym !== 2'b11) begin
      n_fail++;
      $display("FAIL midreset pre: busy=%b sym=%b, want 1 11", busy, sym);
    end
    #2;
    reset = 1'b0;
    #1;
    n_assert++;
    if (sym !== 2'b00 || sym_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset async: sym=%b valid=%b busy=%b, want 00 0 0", sym, sym_valid, busy);
    end
    model_reset();
    raw_in = 2'b00;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_random();
    logic [1:0] v;
    int         len;
    for (int k = 0; k < 80; k++) begin
      v   = 2'($urandom_range(0, 3));
      len = $urandom_range(1, 7);
      for (int j = 0; j < len; j++) begin
        step(v);
        n_assert++;
        if (sym !== m_sym || sym_valid !== m_valid || busy !== (m_run > 0)) begin
          n_fail++;
          $display("FAIL random k%0d j%0d: sym=%b valid=%b busy=%b, want %b %b %b",
                   k, j, sym, sym_valid, busy, m_sym, m_valid, (m_run > 0));
        end
      end
    end
  endtask

  task automatic test_repeat();
    int strobes, last, gap_bad;
    for (int i = 0; i < 10; i++) step(2'b00);
    strobes = 0; last = -1; gap_bad = 0;
    for (int i = 0; i < 60; i++) begin
      step(2'b01);
      if (sym_valid) begin
        if (last >= 0 && (i - last) != R) gap_bad++;
        last = i;
        strobes++;
      end
      n_assert++;
      if (sym !== m_sym || sym_valid !== m_valid) begin
        n_fail++;
        $display("FAIL repeat hold cyc%0d: sym=%b valid=%b, want %b %b", i, sym, sym_valid, m_sym, m_valid);
      end
    end
`ifdef INPUT_CONDITIONER_REPEAT_EN
    // Commit lands at i=D+1; repeats follow every R cycles within 60.
    n_assert++;
    if (strobes != 1 + (59 - (D + 1)) / R || gap_bad != 0) begin
      n_fail++;
      $display("FAIL repeat count: strobes=%0d badgaps=%0d, want %0d 0", strobes, gap_bad, 1 + (59 - (D + 1)) / R);
    end
`else
    n_assert++;
    if (strobes != 1) begin
      n_fail++;
      $display("FAIL repeat disabled: strobes=%0d, want 1", strobes);
    end
`endif
    strobes = 0;
    for (int i = 0; i < 40; i++) begin
      step(2'b00);
      if (sym_valid) strobes++;
    end
    n_assert++;
    if (strobes != 1 || sym !== 2'b00) begin
      n_fail++;
      $display("FAIL repeat release: strobes=%0d sym=%b, want 1 00", strobes, sym);
    end
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    reset    = 1'b0;
    raw_in   = 2'b00;
    test_reset();
    test_clean();
    test_glitch();
    test_bounce();
    test_back_to_back();
    test_reset_mid();
    test_random();
    test_repeat();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
